// File: rtl/keymux_pkg.sv
// Shared constants for the keyed lookup table: default geometry and the
// index-width helper used by every module that carries an entry index.
package keymux_pkg;

  localparam int DEF_NR_KEY      = 4;
  localparam int DEF_KEY_LEN     = 2;
  localparam int DEF_DATA_LEN    = 2;
  localparam int DEF_HAS_DEFAULT = 1;
  localparam int DEF_CNT_W       = 8;

  // Width of an entry index; a single-entry table still needs one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/keymux_match.sv
// Priority key match: compares one key against every valid entry and reports
// the lowest matching index. Purely combinational.
module keymux_match
  import keymux_pkg::*;
#(
  parameter int NR_KEY  = DEF_NR_KEY,
  parameter int KEY_LEN = DEF_KEY_LEN,
  parameter int IDX_W   = idx_w(DEF_NR_KEY)
) (
  input  logic [KEY_LEN-1:0]        key,
  input  logic [NR_KEY-1:0]         valid,
  input  logic [NR_KEY*KEY_LEN-1:0] keys,
  output logic                      hit,
  output logic [IDX_W-1:0]          idx
);

  // Scan from the top down so the lowest matching index is the last writer.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (valid[i] && (keys[i*KEY_LEN +: KEY_LEN] == key)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/keymux_table.sv
// Keyed lookup table with one registered output stage.
//
// Handshake: a lookup is accepted on a rising edge where in_valid && in_ready;
// a result is consumed on a rising edge where out_valid && out_ready. in_ready
// is high whenever the output register is empty or is being drained this
// cycle, so back-to-back lookups flow at one per cycle while out_ready is high.
// While out_valid && !out_ready the result fields are held unchanged.
//
// Lookups always see the table as it was before the edge; a write or clear in
// the same cycle only becomes visible to the next lookup.
module keymux_table
  import keymux_pkg::*;
#(
  parameter int NR_KEY      = DEF_NR_KEY,
  parameter int KEY_LEN     = DEF_KEY_LEN,
  parameter int DATA_LEN    = DEF_DATA_LEN,
  parameter int HAS_DEFAULT = DEF_HAS_DEFAULT,
  parameter int CNT_W       = DEF_CNT_W,
  localparam int IDX_W      = idx_w(NR_KEY)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [KEY_LEN-1:0]  in_key,
  input  logic [DATA_LEN-1:0] default_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_data,
  output logic                out_hit,
  output logic [IDX_W-1:0]    out_idx,
  output logic [CNT_W-1:0]    miss_cnt
);

  logic [NR_KEY-1:0]         valid_q;
  logic [KEY_LEN-1:0]        key_q  [NR_KEY];
  logic [DATA_LEN-1:0]       data_q [NR_KEY];
  logic [NR_KEY*KEY_LEN-1:0] keys_flat;

  logic                m_hit;
  logic [IDX_W-1:0]    m_idx;
  logic                accept;
  logic                wr_ok;
  logic [DATA_LEN-1:0] miss_data;

  for (genvar g = 0; g < NR_KEY; g++) begin : g_flat
    assign keys_flat[g*KEY_LEN +: KEY_LEN] = key_q[g];
  end

  keymux_match #(
    .NR_KEY (NR_KEY),
    .KEY_LEN(KEY_LEN),
    .IDX_W  (IDX_W)
  ) u_match (
    .key  (in_key),
    .valid(valid_q),
    .keys (keys_flat),
    .hit  (m_hit),
    .idx  (m_idx)
  );

  // Indices past the last entry exist when NR_KEY is not a power of two.
  assign wr_ok     = (int'(wr_idx) < NR_KEY);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign miss_data = (HAS_DEFAULT != 0) ? default_out : '0;

  // Table storage: clear beats a same-cycle write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < NR_KEY; i++) begin
        key_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (clr) begin
      valid_q <= '0;
    end else if (wr_en && wr_ok) begin
      valid_q[wr_idx] <= 1'b1;
      key_q[wr_idx]   <= wr_key;
      data_q[wr_idx]  <= wr_data;
    end
  end

  // Output register and saturating miss counter; untouched by clr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_hit   <= 1'b0;
      out_idx   <= '0;
      miss_cnt  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= m_hit ? data_q[m_idx] : miss_data;
      out_hit   <= m_hit;
      out_idx   <= m_hit ? m_idx : '0;
      if (!m_hit && (miss_cnt != {CNT_W{1'b1}})) begin
        miss_cnt <= miss_cnt + CNT_W'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/keymux_table.md
KEYMUX_TABLE -- requirements
Module: keymux_table

Interface
REQ-001 SHALL have parameter NR_KEY, default 4, number of table entries (>=2).
REQ-002 SHALL have parameter KEY_LEN, default 2, key width in bits.
REQ-003 SHALL have parameter DATA_LEN, default 2, data width in bits.
REQ-004 SHALL have parameter HAS_DEFAULT, default 1; 1 = miss returns default_out, 0 = miss returns zero.
REQ-005 SHALL have parameter CNT_W, default 8, miss-counter width.
REQ-006 SHALL use one clock and a synchronous, active-low reset; there is no other clock or reset.
REQ-007 SHALL have the following ports (IDX_W = clog2(NR_KEY)):
  clk  input  1  sole clock, rising edge
  rst_n  input  1  synchronous active-low reset
  wr_en  input  1  write one table entry this cycle
  wr_idx  input  IDX_W  entry index to write
  wr_key  input  KEY_LEN  key stored in the entry
  wr_data  input  DATA_LEN  data stored in the entry
  clr  input  1  invalidate all entries
  in_valid  input  1  lookup request valid
  in_ready  output  1  lookup request accepted when high with in_valid
  in_key  input  KEY_LEN  lookup key
  default_out  input  DATA_LEN  miss value, sampled at accept
  out_valid  output  1  result valid
  out_ready  input  1  downstream accepts result
  out_data  output  DATA_LEN  looked-up data
  out_hit  output  1  1 = key matched a valid entry
  out_idx  output  IDX_W  matching entry index (0 on miss)
  miss_cnt  output  CNT_W  saturating count of accepted misses

Function
REQ-008 SHALL hold NR_KEY entries, each {valid, key, data}; a write sets valid=1, key=wr_key, data=wr_data at wr_idx on the next edge.
REQ-009 SHALL ignore wr_en when wr_idx >= NR_KEY (non-power-of-2 depth).
REQ-010 SHALL clear all valid bits on clr; clr and wr_en in the same cycle: clr wins, the write is dropped.
REQ-011 SHALL match in_key against all valid entries; with multiple matches the lowest index wins (priority, not OR).
REQ-012 SHALL produce data on a hit; on a miss, default_out if HAS_DEFAULT=1, else zero.
REQ-013 SHALL accept a lookup when in_valid && in_ready; the result appears on out_* exactly one cycle after accept.
REQ-014 SHALL drive in_ready = !out_valid || out_ready (single output stage, full throughput when out_ready=1).
REQ-015 SHALL hold out_data, out_hit and out_idx stable while out_valid && !out_ready.
REQ-016 SHALL clear out_valid after out_valid && out_ready when no new accept occurs in that cycle.
REQ-017 SHALL make a lookup and a write or clr in the same cycle see the pre-edge table (the write takes effect next cycle).
REQ-018 SHALL increment miss_cnt by 1 per accepted miss, saturating at 2^CNT_W-1 with no wrap.
REQ-019 SHALL keep the output register and miss_cnt unchanged by clr; clr affects only the table.

Reset
REQ-020 SHALL, when rst_n=0 at an edge: all valid bits=0, keys and data=0, out_valid=0, out_data=0, out_hit=0, out_idx=0, miss_cnt=0.
REQ-021 SHALL discard a result pending during reset; in_ready reads 1 in the first cycle after reset.
REQ-022 SHALL let reset override wr_en, clr and in_valid in the same cycle.

Structure
REQ-023 SHALL place the shared constants (default widths, the IDX_W computation function) in a shared package, keymux_pkg.
REQ-024 SHALL factor the combinational priority match into one sub-module, keymux_match (inputs: key, valid and key vectors; outputs: hit, idx).
REQ-025 SHALL keep keymux_table to a single always block for the table plus one for the output stage and counter, within 120-400 RTL lines.

Verification
REQ-026 Write idx0={01,10}, idx1={10,11}; look up 10 -> next cycle out_valid=1, out_hit=1, out_idx=1, out_data=11.
REQ-027 Write idx0={01,10}, idx2={01,00}; look up 01 -> out_idx=0, out_data=10 (lowest index wins).
REQ-028 HAS_DEFAULT=1, empty table, default_out=11, look up 00 -> out_hit=0, out_data=11, miss_cnt=1; with HAS_DEFAULT=0 -> out_data=00.
REQ-029 out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0 and out_* stable; raise out_ready with in_valid=1 -> a new result follows next cycle, no cycle is lost.
REQ-030 Same cycle: clr=1, wr_en=1 (idx0={00,01}) and lookup 00 on a previously valid idx0={00,10} -> result out_data=10 (hit); the following lookup of 00 misses.
REQ-031 CNT_W=2, 5 accepted misses -> miss_cnt=3; assert rst_n=0 mid-stall -> out_valid=0, miss_cnt=0, all entries invalid.
